screen_selector: RTL and testbench

- Game-flow controller and VGA source multiplexer. Sits directly downstream of the start, game, win and lose screen stages.
- Runs the top-level game state machine from a debounced start button and the game_won / game_lost flags.
- Forwards exactly one screen's VGA stream to the output stage.
- Switches the displayed screen only on frame boundaries, so no frame is ever torn.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_if.sv | 15 +
 rtl/btn_debounce.sv | 43 ++++
 rtl/screen_selector.sv | 99 +++++++++
 tb/tb_screen_selector.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA stream type, game states and default timing constants
package vga_pkg;

    typedef enum logic [1:0] {ST_START, ST_PLAY, ST_WIN, ST_LOSE} game_state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam int DEBOUNCE_CYCLES_DEF = 65000;
    localparam int HOLD_FRAMES_DEF     = 60;

endpackage

// File: rtl/vga_if.sv
// vga_if: one VGA pixel stream with timing fields and 12-bit colour
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise a raw button, debounce it and pulse on each press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, stable_q, stable_d, press_q, hit;
    logic [CW-1:0] cnt_q, cnt_d;

    // the synchronised level must disagree with the stable level for
    // DEBOUNCE_CYCLES consecutive cycles before it is accepted
    always_comb begin
        hit      = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || hit) ? '0 : cnt_q + 1'b1;
        stable_d = hit ? sync2_q : stable_q;
    end

    // synchroniser, debounce state and registered press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= hit & sync2_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/screen_selector.sv
// screen_selector: game-flow FSM and tear-free VGA screen multiplexer
module screen_selector
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_FRAMES     = HOLD_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        game_won,
    input  logic        game_lost,
    vga_if.in           vga_start_in,
    vga_if.in           vga_game_in,
    vga_if.in           vga_win_in,
    vga_if.in           vga_lose_in,
    vga_if.out          vga_out,
    output game_state_t game_state,
    output logic        game_active
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    game_state_t   state_q, state_d, disp_q, disp_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          btn_press, vblnk_q, frame_start, held, entering, active_q;
    logic [11:0]   sel_rgb;
    vga_t          out_q, out_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (start_btn),
        .press_o(btn_press)
    );

    // next game state; presses during the hold period are simply dropped
    always_comb begin
        state_d = state_q;
        held    = hold_q == HW'(HOLD_FRAMES);
        unique case (state_q)
            ST_START: state_d = btn_press ? ST_PLAY : ST_START;
            ST_PLAY:  state_d = game_won ? ST_WIN : game_lost ? ST_LOSE : ST_PLAY;
            default:  state_d = (btn_press && held) ? ST_START : state_q;
        endcase
    end

    // frame tick, displayed screen (latched only at frame start) and hold count
    always_comb begin
        frame_start = vga_start_in.vblnk & ~vblnk_q;
        disp_d      = frame_start ? state_q : disp_q;
        entering    = (state_q == ST_PLAY) && (state_d != ST_PLAY);
        hold_d      = entering ? '0
                    : (frame_start && (disp_q == ST_WIN || disp_q == ST_LOSE) && !held) ? hold_q + 1'b1
                    : hold_q;
    end

    // pick the displayed stream's colour, black during blanking
    always_comb begin
        sel_rgb = disp_q == ST_PLAY ? vga_game_in.rgb
                : disp_q == ST_WIN  ? vga_win_in.rgb
                : disp_q == ST_LOSE ? vga_lose_in.rgb
                : vga_start_in.rgb;
        out_d   = '{hcount: vga_start_in.hcount, vcount: vga_start_in.vcount,
                    hsync: vga_start_in.hsync, vsync: vga_start_in.vsync,
                    hblnk: vga_start_in.hblnk, vblnk: vga_start_in.vblnk,
                    rgb: (vga_start_in.hblnk | vga_start_in.vblnk) ? 12'h000 : sel_rgb};
    end

    // state, selection, hold and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_START;
            disp_q   <= ST_START;
            hold_q   <= '0;
            vblnk_q  <= 1'b0;
            active_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            hold_q   <= hold_d;
            vblnk_q  <= vga_start_in.vblnk;
            active_q <= disp_d == ST_PLAY;
            out_q    <= out_d;
        end
    end

    assign vga_out.hcount = out_q.hcount;
    assign vga_out.vcount = out_q.vcount;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.rgb    = out_q.rgb;
    assign game_state     = state_q;
    assign game_active    = active_q;

endmodule

// File: tb/tb_screen_selector.sv
// tb_screen_selector: randomized and directed checks against a game-flow reference model
module tb_screen_selector;
    import vga_pkg::*;

    localparam int D  = 4;
    localparam int H  = 3;
    localparam int HT = 16;
    localparam int HA = 10;
    localparam int VT = 12;
    localparam int VA = 8;
    localparam int FS = VA * HT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0, game_won = 1'b0, game_lost = 1'b0;
    game_state_t game_state;
    logic        game_active;

    vga_if s_if ();
    vga_if g_if ();
    vga_if w_if ();
    vga_if l_if ();
    vga_if o_if ();

    screen_selector #(.DEBOUNCE_CYCLES(D), .HOLD_FRAMES(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .game_won    (game_won),
        .game_lost   (game_lost),
        .vga_start_in(s_if),
        .vga_game_in (g_if),
        .vga_win_in  (w_if),
        .vga_lose_in (l_if),
        .vga_out     (o_if),
        .game_state  (game_state),
        .game_active (game_active)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int hc = 0, vc = 0;
    logic btn = 1'b0, won = 1'b0, lost = 1'b0;

    int   m_state, m_disp, m_hold, m_run, m_stable, m_press, m_pvb;
    logic rawq[$];
    logic [11:0] e_rgb;
    logic [25:0] e_tim;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_disp = 0; m_hold = 0; m_run = 0;
        m_stable = 0; m_press = 0; m_pvb = 0;
        rawq.delete();
        e_rgb = '0; e_tim = '0;
    endtask

    // one clock of the game rules: button seen two clocks late, accepted after
    // D disagreeing clocks, press acts one clock after acceptance
    task automatic model_edge();
        int s2, st, hold, press, fs;
        logic [11:0] r;
        s2    = rawq.size() >= 2 ? int'(rawq[rawq.size()-2]) : 0;
        press = 0;
        if (s2 != m_stable) begin
            m_run++;
            if (m_run == D) begin
                m_stable = s2;
                press    = s2;
                m_run    = 0;
            end
        end else m_run = 0;
        rawq.push_back(start_btn);
        if (rawq.size() > 4) void'(rawq.pop_front());
        fs = (s_if.vblnk && m_pvb == 0) ? 1 : 0;
        st = m_state;
        if (m_state == 0 && m_press != 0) st = 1;
        else if (m_state == 1) st = game_won ? 2 : game_lost ? 3 : 1;
        else if (m_state >= 2 && m_press != 0 && m_hold == H) st = 0;
        hold = m_hold;
        if (m_state == 1 && st != 1) hold = 0;
        else if (fs != 0 && m_disp >= 2 && m_hold < H) hold++;
        case (m_disp)
            1: r = g_if.rgb;
            2: r = w_if.rgb;
            3: r = l_if.rgb;
            default: r = s_if.rgb;
        endcase
        e_rgb = (s_if.hblnk || s_if.vblnk) ? 12'h000 : r;
        e_tim = {s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync, s_if.hblnk, s_if.vblnk};
        if (fs != 0) m_disp = m_state;
        m_state = st;
        m_hold  = hold;
        m_press = press;
        m_pvb   = int'(s_if.vblnk);
    endtask

    task automatic cyc();
        @(negedge clk);
        start_btn = btn; game_won = won; game_lost = lost;
        s_if.hcount = 11'(hc); s_if.vcount = 11'(vc);
        s_if.hsync = hc >= 12 && hc < 14; s_if.vsync = vc == 9;
        s_if.hblnk = hc >= HA; s_if.vblnk = vc >= VA;
        g_if.hcount = s_if.hcount; g_if.vcount = s_if.vcount; g_if.hsync = s_if.hsync;
        g_if.vsync = s_if.vsync; g_if.hblnk = s_if.hblnk; g_if.vblnk = s_if.vblnk;
        s_if.rgb = 12'($urandom); g_if.rgb = 12'($urandom);
        w_if.rgb = 12'($urandom); l_if.rgb = 12'($urandom);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("state", 32'(game_state), 32'(m_state));
        chk("active", 32'(game_active), 32'(m_disp == 1));
        chk("rgb", 32'(o_if.rgb), 32'(e_rgb));
        chk("timing", 32'({o_if.hcount, o_if.vcount, o_if.hsync, o_if.vsync, o_if.hblnk, o_if.vblnk}), 32'(e_tim));
        hc = hc + 1;
        if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_to(input int p);
        int last;
        do begin
            last = vc * HT + hc;
            cyc();
        end while (last != p);
    endtask

    task automatic press();
        btn = 1'b1; run(10);
        btn = 1'b0; run(10);
    endtask

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        chk("rst_state", 32'(game_state), 32'(ST_START));
        chk("rst_active", 32'(game_active), 0);
        run(2 * VT * HT);
        btn = 1'b1; run(3);
        btn = 1'b0; run(10);
        chk("glitch", 32'(game_state), 32'(ST_START));
        press();
        chk("press", 32'(game_state), 32'(ST_PLAY));
        chk("act_pre", 32'(game_active), 0);
        run_to(FS);
        chk("act_post", 32'(game_active), 1);
        run(20);
        won = 1'b1; lost = 1'b1; run(1);
        won = 1'b0; lost = 1'b0;
        chk("won_prio", 32'(game_state), 32'(ST_WIN));
        run_to(FS);
        chk("win_shown", 32'(game_active), 0);
        for (int i = 0; i < 4; i++) run_to(FS);
        press();
        chk("win_exit", 32'(game_state), 32'(ST_START));
        run_to(FS);
        press();
        run_to(FS);
        lost = 1'b1; run(1);
        lost = 1'b0;
        chk("lose", 32'(game_state), 32'(ST_LOSE));
        run_to(FS);
        press();
        chk("hold_f1", 32'(game_state), 32'(ST_LOSE));
        run_to(FS); run_to(FS);
        press();
        chk("hold_f3", 32'(game_state), 32'(ST_LOSE));
        run_to(FS);
        press();
        chk("hold_rel", 32'(game_state), 32'(ST_START));
        run_to(FS);
        run(20);
        run_to(FS - 7);
        btn = 1'b1;
        run_to(FS);
        chk("coinc_st", 32'(game_state), 32'(ST_PLAY));
        chk("coinc_old", 32'(game_active), 0);
        btn = 1'b0;
        run_to(FS);
        chk("coinc_new", 32'(game_active), 1);
        run(50);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rgb", 32'(o_if.rgb), 0);
        chk("arst_hc", 32'(o_if.hcount), 0);
        chk("arst_state", 32'(game_state), 32'(ST_START));
        chk("arst_active", 32'(game_active), 0);
        model_reset();
        run(3);
        rst = 1'b0;
        run(2 * VT * HT);
        for (int i = 0; i < 40 * VT * HT; i++) begin
            if ($urandom_range(0, 29) == 0) btn = ~btn;
            won  = $urandom_range(0, 199) == 0;
            lost = $urandom_range(0, 199) == 0;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
